// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : W-bit signed arithmetic/logic unit with an internal accumulator.
//   Execute stage of the processor datapath. One operation per clock edge:
//   operands and opcode are sampled on the rising edge, and the registered
//   result and flags appear after that edge.
//
// Ports
//   clk               in   system clock, rising-edge active
//   rst               in   synchronous active-high reset (clears result/flags)
//   alu_op[4:0]       in   operation select
//   operandA[W-1:0]   in   signed operand A
//   operandB[W-1:0]   in   signed operand B (low $clog2(W) bits = shift amount)
//   resultAccumulator out  registered result / accumulator
//   flags[3:0]        out  registered {Z, N, C, V}
// ---------------------------------------------------------------------------
module alu #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          alu_op,
  input  logic signed [W-1:0] operandA,
  input  logic signed [W-1:0] operandB,
  output logic signed [W-1:0] resultAccumulator,
  output logic [3:0]          flags
);

  localparam int SW = $clog2(W);
  localparam logic signed [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] ONE_S = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_MUL = 5'd3,
    OP_DIV = 5'd4,  OP_MOD = 5'd5,  OP_AND = 5'd6,  OP_OR  = 5'd7,
    OP_XOR = 5'd8,  OP_LSL = 5'd9,  OP_LSR = 5'd10, OP_ROL = 5'd11,
    OP_ROR = 5'd12, OP_NOT = 5'd13, OP_INC = 5'd14, OP_DEC = 5'd15,
    OP_CMP = 5'd16, OP_TST = 5'd17, OP_MOV = 5'd18, OP_NEG = 5'd19,
    OP_ACC = 5'd20, OP_CLR = 5'd21
  } op_e;

  // Returns {carry, overflow, sum}.
  function automatic logic [W+1:0] add_cv(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b};
    v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {s[W], v, s[W-1:0]};
  endfunction

  // Returns {borrow, overflow, difference}; bit W of the widened difference
  // is set exactly when the unsigned minuend is below the subtrahend.
  function automatic logic [W+1:0] sub_cv(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    logic       v;
    d = {1'b0, a} - {1'b0, b};
    v = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {d[W], v, d[W-1:0]};
  endfunction

  logic signed [W-1:0] res_q, res_d;
  logic [3:0]          flags_q, flags_d;

  op_e                 op;
  logic [SW-1:0]       s;
  logic [SW:0]         s_inv;
  logic [W-1:0]        a_u, b_u, acc_u;
  logic [W:0]          lsl_ext, lsr_ext;
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0] div_b, quot, rem;
  logic [W+1:0]        cvr;
  logic [W-1:0]        val;
  logic                c, v, wr_res, wr_flags;

  assign op    = op_e'(alu_op);
  assign s     = operandB[SW-1:0];
  assign s_inv = (SW+1)'(W) - {1'b0, s};
  assign a_u   = operandA;
  assign b_u   = operandB;
  assign acc_u = res_q;

  // Shift carries come from one extra bit beyond the word on the shifted-out
  // side; with S=0 that bit stays zero.
  assign lsl_ext = {1'b0, a_u} << s;
  assign lsr_ext = {a_u, 1'b0} >> s;
  assign prod    = operandA * operandB;
  // Divisor forced non-zero so the divider never sees 0; the result is
  // overridden for that case anyway.
  assign div_b   = (operandB == '0) ? ONE_S : operandB;
  assign quot    = operandA / div_b;
  assign rem     = operandA % div_b;

  always_comb begin
    val      = '0;
    c        = 1'b0;
    v        = 1'b0;
    cvr      = '0;
    wr_res   = 1'b1;
    wr_flags = 1'b1;
    case (op)
      OP_ADD: begin cvr = add_cv(a_u, b_u);   {c, v, val} = cvr; end
      OP_SUB: begin cvr = sub_cv(a_u, b_u);   {c, v, val} = cvr; end
      OP_INC: begin cvr = add_cv(a_u, ONE_S); {c, v, val} = cvr; end
      OP_DEC: begin cvr = sub_cv(a_u, ONE_S); {c, v, val} = cvr; end
      OP_ACC: begin cvr = add_cv(acc_u, a_u); {c, v, val} = cvr; end
      OP_CMP: begin cvr = sub_cv(a_u, b_u);   {c, v, val} = cvr; wr_res = 1'b0; end
      OP_NEG: begin
        cvr = sub_cv('0, a_u);
        val = cvr[W-1:0];
        c   = cvr[W+1];
        v   = (operandA == MIN_S);
      end
      OP_MUL: begin
        val = prod[W-1:0];
        // Product fits only if the upper W+1 bits are pure sign extension.
        v   = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));
      end
      OP_DIV: begin
        if (operandB == '0) begin
          val = '0;
          v   = 1'b1;
        end else if (operandA == MIN_S && operandB == -ONE_S) begin
          val = MIN_S;
          v   = 1'b1;
        end else begin
          val = quot;
        end
      end
      OP_MOD: begin
        if (operandB == '0) begin
          val = '0;
          v   = 1'b1;
        end else if (operandA == MIN_S && operandB == -ONE_S) begin
          val = '0;
        end else begin
          val = rem;
        end
      end
      OP_AND: val = a_u & b_u;
      OP_OR:  val = a_u | b_u;
      OP_XOR: val = a_u ^ b_u;
      OP_TST: begin val = a_u & b_u; wr_res = 1'b0; end
      OP_LSL: begin val = lsl_ext[W-1:0]; c = lsl_ext[W]; end
      OP_LSR: begin val = lsr_ext[W:1];   c = lsr_ext[0]; end
      OP_ROL: val = (a_u << s) | (a_u >> s_inv);
      OP_ROR: val = (a_u >> s) | (a_u << s_inv);
      OP_NOT: val = ~a_u;
      OP_MOV: val = a_u;
      OP_CLR: val = '0;
      default: begin
        wr_res   = 1'b0;
        wr_flags = 1'b0;
      end
    endcase
    res_d   = wr_res   ? val : res_q;
    flags_d = wr_flags ? {(val == '0), val[W-1], c, v} : flags_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      flags_q <= 4'b0000;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign resultAccumulator = res_q;
  assign flags             = flags_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  localparam int W = 16;
  localparam longint MAXS = 32767;
  localparam longint MINS = -32768;

  logic                clk = 1'b0;
  logic                rst;
  logic [4:0]          alu_op;
  logic signed [W-1:0] operandA, operandB;
  logic signed [W-1:0] resultAccumulator;
  logic [3:0]          flags;

  alu #(.W(W)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op),
    .operandA(operandA), .operandB(operandB),
    .resultAccumulator(resultAccumulator), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_res = '0;
  logic [3:0]   m_fl  = '0;

  function automatic logic [W-1:0] wrap(input longint x);
    return W'(x);
  endfunction

  // Behavioural reference: integer arithmetic straight from the opcode rules.
  task automatic model(input logic r, input logic [4:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub, full;
    int s;
    logic [W-1:0] v16;
    logic cf, vf, wres, wfl;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    s  = int'(b[3:0]);
    v16 = '0; cf = 0; vf = 0; wres = 1; wfl = 1;
    if (r) begin
      m_res = '0; m_fl = '0;
      return;
    end
    case (op)
      5'd1, 5'd14, 5'd20: begin
        if (op == 5'd14) begin sb = 1; ub = 1; end
        if (op == 5'd20) begin sb = sa; ub = ua; sa = longint'($signed(m_res)); ua = longint'(m_res); end
        full = sa + sb; v16 = wrap(full);
        cf = (ua + ub) > 65535; vf = (full > MAXS) || (full < MINS);
      end
      5'd2, 5'd15, 5'd16: begin
        if (op == 5'd15) begin sb = 1; ub = 1; end
        full = sa - sb; v16 = wrap(full);
        cf = ua < ub; vf = (full > MAXS) || (full < MINS);
        if (op == 5'd16) wres = 0;
      end
      5'd19: begin v16 = wrap(-sa); cf = ua != 0; vf = (sa == MINS); end
      5'd3: begin full = sa * sb; v16 = wrap(full); vf = (full > MAXS) || (full < MINS); end
      5'd4: begin
        if (sb == 0) begin v16 = 0; vf = 1; end
        else if (sa == MINS && sb == -1) begin v16 = wrap(MINS); vf = 1; end
        else v16 = wrap(sa / sb);
      end
      5'd5: begin
        if (sb == 0) begin v16 = 0; vf = 1; end
        else v16 = wrap(sa % sb);
      end
      5'd6: v16 = a & b;
      5'd7: v16 = a | b;
      5'd8: v16 = a ^ b;
      5'd17: begin v16 = a & b; wres = 0; end
      5'd9:  begin v16 = wrap(ua << s); cf = (s != 0) && (((ua >> (16 - s)) & 1) == 1); end
      5'd10: begin v16 = wrap(ua >> s); cf = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      5'd11: v16 = wrap((ua << s) | (ua >> (16 - s)));
      5'd12: v16 = wrap((ua >> s) | (ua << (16 - s)));
      5'd13: v16 = ~a;
      5'd18: v16 = a;
      5'd21: v16 = 0;
      default: begin wres = 0; wfl = 0; end
    endcase
    if (wfl) m_fl = {(v16 == 0), v16[W-1], cf, vf};
    if (wres) m_res = v16;
  endtask

  // Apply one operation at the falling edge and queue what it must produce.
  // When has_exp is set the directed constant is queued instead of the model's value.
  task automatic issue(input string nm, input logic r, input logic [4:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic has_exp, input logic [W-1:0] er, input logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    rst = r; alu_op = op; operandA = a; operandB = b;
    model(r, op, a, b);
    e.name = nm;
    e.res  = has_exp ? er : m_res;
    e.fl   = has_exp ? ef : m_fl;
    sbq.push_back(e);
  endtask

  // Monitor: the DUT presents a new result every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (resultAccumulator !== e.res) begin
        errors++;
        $display("FAIL %s result got %h want %h", e.name, resultAccumulator, e.res);
      end
      checks++;
      if (flags !== e.fl) begin
        errors++;
        $display("FAIL %s flags got %b want %b", e.name, flags, e.fl);
      end
    end
  end

  typedef struct {
    string        nm;
    logic         r;
    logic [4:0]   op;
    logic [W-1:0] a, b, er;
    logic [3:0]   ef;
  } dir_t;

  dir_t dir[$];

  function automatic logic [W-1:0] pick();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h7FFF;
      4: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int wait_cyc;
    rst = 1'b0; alu_op = '0; operandA = '0; operandB = '0;
    dir = '{
      '{"rst_add", 1, 5'd1,  16'd5,    16'd7,    16'h0000, 4'b0000},
      '{"add",     0, 5'd1,  16'd5,    16'd7,    16'd12,   4'b0000},
      '{"not-32",  0, 5'd13, 16'hFFE0, 16'd0,    16'd31,   4'b0000},
      '{"not-13",  0, 5'd13, 16'hFFF3, 16'd0,    16'd12,   4'b0000},
      '{"not0",    0, 5'd13, 16'h0000, 16'd0,    16'hFFFF, 4'b0100},
      '{"not347",  0, 5'd13, 16'd347,  16'd0,    16'hFEA4, 4'b0100},
      '{"add_ovf", 0, 5'd1,  16'h7FFF, 16'd1,    16'h8000, 4'b0101},
      '{"add_z",   0, 5'd1,  16'hFFFF, 16'd1,    16'h0000, 4'b1010},
      '{"sub",     0, 5'd2,  16'd3,    16'd5,    16'hFFFE, 4'b0110},
      '{"cmp",     0, 5'd16, 16'd7,    16'd7,    16'hFFFE, 4'b1000},
      '{"div",     0, 5'd4,  16'd7,    16'hFFFE, 16'hFFFD, 4'b0100},
      '{"mod",     0, 5'd5,  16'hFFF9, 16'd2,    16'hFFFF, 4'b0100},
      '{"div0",    0, 5'd4,  16'd100,  16'd0,    16'h0000, 4'b1001},
      '{"clr",     0, 5'd21, 16'd9,    16'd9,    16'h0000, 4'b1000},
      '{"acc1",    0, 5'd20, 16'd10,   16'd0,    16'd10,   4'b0000},
      '{"acc2",    0, 5'd20, 16'd10,   16'd0,    16'd20,   4'b0000},
      '{"acc3",    0, 5'd20, 16'd10,   16'd0,    16'd30,   4'b0000},
      '{"rol",     0, 5'd11, 16'h8001, 16'd1,    16'h0003, 4'b0000},
      '{"lsl",     0, 5'd9,  16'h8001, 16'd1,    16'h0002, 4'b0010},
      '{"neg_min", 0, 5'd19, 16'h8000, 16'd0,    16'h8000, 4'b0111},
      '{"mul_ovf", 0, 5'd3,  16'd300,  16'd300,  16'h5F90, 4'b0001},
      '{"div_min", 0, 5'd4,  16'h8000, 16'hFFFF, 16'h8000, 4'b0101},
      '{"nop",     0, 5'd0,  16'd1,    16'd1,    16'h8000, 4'b0101},
      '{"tst",     0, 5'd17, 16'h00F0, 16'h0F00, 16'h8000, 4'b1000},
      '{"lsr",     0, 5'd10, 16'h0003, 16'd1,    16'h0001, 4'b0010},
      '{"ror",     0, 5'd12, 16'h0001, 16'd1,    16'h8000, 4'b0100},
      '{"op31",    0, 5'd31, 16'd5,    16'd5,    16'h8000, 4'b0100},
      '{"xor",     0, 5'd8,  16'h00FF, 16'h00FF, 16'h0000, 4'b1000},
      '{"lsl_s0",  0, 5'd9,  16'h0001, 16'h0010, 16'h0001, 4'b0000}
    };
    foreach (dir[i])
      issue(dir[i].nm, dir[i].r, dir[i].op, dir[i].a, dir[i].b, 1'b1, dir[i].er, dir[i].ef);

    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 49) == 0);
      issue("rand", r, 5'($urandom_range(0, 31)), pick(), pick(), 1'b0, '0, '0);
    end

    @(negedge clk);
    rst = 1'b0; alu_op = 5'd0;
    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Synchronous W-bit signed arithmetic/logic unit with an internal accumulator register.
- A 5-bit opcode selects the operation on operandA/operandB.
- The result is registered into resultAccumulator, and condition flags are registered alongside it.
- Serves as the datapath execute stage of the processor; the control unit drives alu_op each cycle.

Parameters:
- W, 16, data width of operands, result and accumulator (two's complement signed).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_op  input  5  operation select (opcode map below).
- operandA  input  W  signed operand A.
- operandB  input  W  signed operand B.
- resultAccumulator  output  W  registered signed result / accumulator contents.
- flags  output  4  registered flags: [3]=Z zero, [2]=N negative, [1]=C carry/borrow, [0]=V overflow.

Behaviour:
- Reset: on a rising clk edge with rst=1, resultAccumulator=0 and flags=4'b0000. Reset has priority over any alu_op.
- Latency: operands and opcode are sampled on the rising edge; result and flags are valid after that edge (1-cycle latency). Outputs hold between edges.
- Opcode map (S = shift amount = operandB[$clog2(W)-1:0]):
  - 00000 NOP: hold result and flags.
  - 00001 ADD: A+B.
  - 00010 SUB: A-B.
  - 00011 MUL: low W bits of the signed product.
  - 00100 DIV: signed quotient, truncated toward zero.
  - 00101 MOD: signed remainder; its sign follows A.
  - 00110 AND: A&B.
  - 00111 OR: A|B.
  - 01000 XOR: A^B.
  - 01001 LSL: A<<S.
  - 01010 LSR: logical A>>S.
  - 01011 ROL: rotate A left by S.
  - 01100 ROR: rotate A right by S.
  - 01101 NOT: ~A (bitwise; B ignored).
  - 01110 INC: A+1.
  - 01111 DEC: A-1.
  - 10000 CMP: compute A-B and update flags only; result holds.
  - 10001 TST: compute A&B and update flags only; result holds.
  - 10010 MOV: A.
  - 10011 NEG: -A.
  - 10100 ACC: resultAccumulator + A (accumulate).
  - 10101 CLR: result=0; flags=Z only.
  - 10110–11111: treated as NOP.
- Z = (new result == 0). N = new result[W-1]. For CMP/TST, Z and N are computed on the discarded value.
- C rules:
  - ADD/INC/ACC: unsigned carry out of bit W-1.
  - SUB/DEC/CMP/NEG: borrow (1 when the unsigned minuend < subtrahend).
  - LSL: last bit shifted out of the MSB. LSR: last bit shifted out of the LSB.
  - S=0 leaves C=0.
  - All other ops: C=0.
- V rules:
  - ADD/SUB/INC/DEC/ACC/CMP: signed overflow (operand signs vs result sign).
  - NEG: V=1 only when A = most-negative value (result wraps to the same value).
  - MUL: V=1 when the full 2W-bit signed product does not fit in W bits.
  - DIV/MOD by zero: result=0, V=1, C=0. DIV of the most-negative value by -1: result = most-negative value, V=1.
  - All logic/shift/rotate/NOT/MOV ops: V=0.
- Width rules: all arithmetic is modulo 2^W; no saturation. Shifts never exceed W-1 because S is truncated.
- Mid-operation reset: rst overrides the opcode in the same cycle; there is no multi-cycle state.

Test Plan:
- rst=1 for one edge with alu_op=ADD, A=5, B=7 -> result=0, flags=0000; after release, ADD 5+7 -> 12, flags=0000.
- NOT sequence, one per clock edge:
  - A=-32 -> 31, flags 0000.
  - A=-13 -> 12.
  - A=0 -> -1 (0xFFFF), N=1.
  - A=347 -> -348, N=1.
- ADD 32767+1 -> -32768, N=1, V=1, C=0; ADD -1+1 -> 0, Z=1, C=1, V=0.
- SUB 3-5 -> -2, N=1, C=1; CMP 7,7 -> result unchanged, Z=1.
- DIV 7/-2 -> -3; MOD -7,2 -> -1; DIV A=100, B=0 -> result 0, V=1.
- CLR then ACC A=10 three times -> 10, 20, 30; ROL 0x8001 by 1 -> 0x0003; LSL 0x8001 by 1 -> 0x0002, C=1.
